digit_scroller: RTL and testbench

- Upstream feeder for the TM1638 display driver.
- Holds a ring of 4-bit digit codes and presents an 8-digit window of that ring on seg0..seg7.
- Advances the window one position every STEP_DIV enable ticks from the clock divider, pausing at the home position.
- Lets the student ID and other messages scroll across the 8-digit TM1638 display.

---
 rtl/digit_scroller.sv | 132 +++++++++++++
 tb/tb_digit_scroller.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/digit_scroller.sv
// digit_scroller: scrolls an 8-digit window over a ring of 4-bit digit codes for the TM1638 driver.
// Optional SCROLL_BLINK_EN blanks the window on alternate dwell steps at the home position.
module digit_scroller #(
    parameter int LEN        = 16,
    parameter int STEP_DIV   = 25,
    parameter int HOLD_STEPS = 4
) (
    input  logic       _50MHz_CLK,
    input  logic       RST_N,
    input  logic       tick,
    input  logic       run,
    input  logic       dir,
    input  logic       load_en,
    input  logic [4:0] load_addr,
    input  logic [3:0] load_data,
    output logic [3:0] seg0,
    output logic [3:0] seg1,
    output logic [3:0] seg2,
    output logic [3:0] seg3,
    output logic [3:0] seg4,
    output logic [3:0] seg5,
    output logic [3:0] seg6,
    output logic [3:0] seg7,
    output logic       wrap
);
    localparam int PW = $clog2(LEN);
    localparam int CW = STEP_DIV > 1 ? $clog2(STEP_DIV) : 1;
    localparam int DW = HOLD_STEPS > 1 ? $clog2(HOLD_STEPS) : 1;
    localparam logic [127:0] INIT = {96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 32'h6619_1122};

    typedef enum logic [1:0] {IDLE, RUN, DWELL} state_t;

    state_t          state, resume, cur;
    logic [PW-1:0]   ptr, nptr;
    logic [CW-1:0]   cnt;
    logic [DW-1:0]   dwell;
    logic            last, blank;
    logic [3:0]      ring  [LEN];
    logic [3:0]      seg_q [8];

    function automatic logic [PW-1:0] widx(input logic [PW-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        return PW'(s >= LEN ? s - LEN : s);
    endfunction

    // IDLE remembers where it came from, so ticks arriving as run rises are not lost
    always_comb begin
        cur  = state == IDLE ? resume : state;
        last = cnt == CW'(STEP_DIV - 1);
        nptr = dir ? (ptr == '0 ? PW'(LEN - 1) : ptr - 1'b1)
                   : (ptr == PW'(LEN - 1) ? '0 : ptr + 1'b1);
    end

`ifdef SCROLL_BLINK_EN
    logic blink;
    assign blank = blink;
`else
    assign blank = 1'b0;
`endif

    always_ff @(posedge _50MHz_CLK or negedge RST_N) begin
        if (!RST_N) begin
            state  <= IDLE;
            resume <= RUN;
            ptr    <= '0;
            cnt    <= '0;
            dwell  <= '0;
            wrap   <= 1'b0;
`ifdef SCROLL_BLINK_EN
            blink  <= 1'b0;
`endif
        end else begin
            wrap <= 1'b0;
            if (!run) begin
                state <= IDLE;
                if (state != IDLE) resume <= state;
            end else begin
                state <= cur;
                if (tick) begin
                    cnt <= last ? '0 : cnt + 1'b1;
                    if (last && cur == RUN) begin
                        ptr  <= nptr;
                        wrap <= dir ? ptr == '0 : ptr == PW'(LEN - 1);
                        if (nptr == '0 && HOLD_STEPS > 0) begin
                            state <= DWELL;
                            dwell <= '0;
                        end
                    end else if (last) begin
                        if (dwell == DW'(HOLD_STEPS - 1)) begin
                            dwell <= '0;
                            state <= RUN;
`ifdef SCROLL_BLINK_EN
                            blink <= 1'b0;
`endif
                        end else begin
                            dwell <= dwell + 1'b1;
`ifdef SCROLL_BLINK_EN
                            blink <= ~blink;
`endif
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge _50MHz_CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < LEN; i++) ring[i] <= INIT[4*i +: 4];
        end else if (load_en && int'(load_addr) < LEN) begin
            ring[load_addr[PW-1:0]] <= load_data;
        end
    end

    always_ff @(posedge _50MHz_CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int k = 0; k < 8; k++) seg_q[k] <= INIT[4*k +: 4];
        end else begin
            for (int k = 0; k < 8; k++) seg_q[k] <= blank ? 4'hF : ring[widx(ptr, k)];
        end
    end

    assign seg0 = seg_q[0];
    assign seg1 = seg_q[1];
    assign seg2 = seg_q[2];
    assign seg3 = seg_q[3];
    assign seg4 = seg_q[4];
    assign seg5 = seg_q[5];
    assign seg6 = seg_q[6];
    assign seg7 = seg_q[7];
endmodule

// File: tb/tb_digit_scroller.sv
// tb_digit_scroller: directed stimulus with queued expectations checked by an independent monitor.
module tb_digit_scroller;
    localparam int LEN = 16;
    localparam int SD  = 2;
    localparam int HS  = 4;
`ifdef SCROLL_BLINK_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0, run = 1'b0, dir = 1'b0, load_en = 1'b0;
    logic [4:0] load_addr = '0;
    logic [3:0] load_data = '0;
    logic [3:0] s0, s1, s2, s3, s4, s5, s6, s7;
    logic       wrap;
    logic [31:0] act;

    logic [32:0] exp_q[$];
    string       name_q[$];
    string       wrap_q[$];
    logic [3:0]  msg[LEN];
    int          total = 0, bad = 0;

    always #5 clk = ~clk;

    digit_scroller #(.LEN(LEN), .STEP_DIV(SD), .HOLD_STEPS(HS)) dut (
        ._50MHz_CLK(clk), .RST_N(rst_n), .tick(tick), .run(run), .dir(dir),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .seg0(s0), .seg1(s1), .seg2(s2), .seg3(s3),
        .seg4(s4), .seg5(s5), .seg6(s6), .seg7(s7), .wrap(wrap)
    );

    assign act = {s7, s6, s5, s4, s3, s2, s1, s0};

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [32:0] e;
            string n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            total++;
            if ({wrap, act} !== e) begin
                bad++;
                $display("FAIL %s: got wrap=%b segs(7..0)=%h required wrap=%b segs(7..0)=%h",
                         n, wrap, act, e[32], e[31:0]);
            end
        end
        if (wrap) begin
            total++;
            if (wrap_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_wrap: got wrap=1 required wrap=0");
            end else begin
                void'(wrap_q.pop_front());
            end
        end
    end

    task automatic reset_msg();
        logic [31:0] id;
        id = 32'h6619_1122;
        for (int i = 0; i < LEN; i++) msg[i] = i < 8 ? id[4*i +: 4] : 4'hF;
    endtask

    function automatic logic [31:0] win(input int p, input bit blk);
        logic [31:0] v;
        for (int k = 0; k < 8; k++) v[4*k +: 4] = blk ? 4'hF : msg[(p + k) % LEN];
        return v;
    endfunction

    task automatic expect_win(input string n, input int p, input bit blk);
        name_q.push_back(n);
        exp_q.push_back({1'b0, win(p, blk)});
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int n);
        repeat (n) begin
            tick = 1'b1;
            cyc(1);
            tick = 1'b0;
            cyc(1);
        end
    endtask

    task automatic load(input int a, input logic [3:0] d, input bit with_tick);
        load_en = 1'b1;
        load_addr = 5'(a);
        load_data = d;
        tick = with_tick;
        cyc(1);
        load_en = 1'b0;
        tick = 1'b0;
        cyc(1);
        if (a < LEN) msg[a] = d;
    endtask

    initial begin
        reset_msg();
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
        expect_win("reset_window", 0, 1'b0);
        cyc(1);
        pulse(3);
        expect_win("tick_while_idle", 0, 1'b0);
        cyc(1);

        run = 1'b1;
        pulse(1);
        load(3, 4'h7, 1'b1);
        expect_win("load_with_step", 1, 1'b0);
        cyc(1);
        load(20, 4'h0, 1'b0);
        expect_win("load_addr_out_of_range", 1, 1'b0);
        cyc(1);
        load(8, 4'h3, 1'b0);
        expect_win("load_in_window", 1, 1'b0);
        cyc(1);

        wrap_q.push_back("lap_wrap");
        pulse(30);
        expect_win("lap_home", 0, 1'b0);
        cyc(1);
        for (int d = 1; d <= HS; d++) begin
            pulse(2);
            expect_win($sformatf("dwell_step%0d", d), 0, BLINK && (d % 2 == 1));
            cyc(1);
        end
        pulse(2);
        expect_win("dwell_resume", 1, 1'b0);
        cyc(1);

        pulse(1);
        run = 1'b0;
        pulse(5);
        expect_win("run_frozen", 1, 1'b0);
        cyc(1);
        run = 1'b1;
        pulse(1);
        expect_win("run_resumed_one_step", 2, 1'b0);
        cyc(1);

        pulse(1);
        dir = 1'b1;
        pulse(1);
        expect_win("dir_change_mid_period", 1, 1'b0);
        cyc(1);

        pulse(1);
        rst_n = 1'b0;
        reset_msg();
        expect_win("async_reset_mid_period", 0, 1'b0);
        cyc(2);
        rst_n = 1'b1;
        cyc(1);

        wrap_q.push_back("reverse_wrap");
        pulse(2);
        expect_win("reverse_from_reset", 15, 1'b0);
        cyc(1);

        run = 1'b0;
        cyc(4);
        total++;
        if (wrap_q.size() != 0) begin
            bad++;
            $display("FAIL missing_wrap: got %0d pulses short, required 0", wrap_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
